// File: rtl/bp_nonsynth_mem_if_monitor.sv
// rtl/bp_nonsynth_mem_if_monitor.sv - runtime protocol monitor for the CCE-to-memory command/response link
//
// Passively observes the mem command and mem response ready-valid channels.
// Accepted commands are queued in order; each accepted response is checked
// against the oldest outstanding command. Errors are sticky and only the
// first one after reset is recorded.
//
// Ports:
//   clk_i, reset_n_i                  clock, synchronous active-low reset
//   mem_cmd_addr_i/opcode_i           command header fields
//   mem_cmd_v_i/ready_and_i           command handshake
//   mem_resp_addr_i/opcode_i          response header fields
//   mem_resp_v_i/ready_and_i          response handshake
//   outstanding_o                     commands currently tracked
//   cmd_count_o, resp_count_o         accepted command/response counts (wrap)
//   error_o, error_code_o             sticky error flag and first error code
module bp_nonsynth_mem_if_monitor #(
    parameter int paddr_width_p     = 40,
    parameter int max_outstanding_p = 8,
    parameter int timeout_p         = 1024,
    parameter int fatal_on_error_p  = 0
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [paddr_width_p-1:0]               mem_cmd_addr_i,
    input  logic [3:0]                             mem_cmd_opcode_i,
    input  logic                                   mem_cmd_v_i,
    input  logic                                   mem_cmd_ready_and_i,
    input  logic [paddr_width_p-1:0]               mem_resp_addr_i,
    input  logic [3:0]                             mem_resp_opcode_i,
    input  logic                                   mem_resp_v_i,
    input  logic                                   mem_resp_ready_and_i,
    output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
    output logic [31:0]                            cmd_count_o,
    output logic [31:0]                            resp_count_o,
    output logic                                   error_o,
    output logic [2:0]                             error_code_o
);
    localparam int ptr_w_lp = $clog2(max_outstanding_p);
    localparam int cnt_w_lp = $clog2(max_outstanding_p+1);
    localparam int age_w_lp = $clog2(timeout_p+1);
    localparam logic [cnt_w_lp-1:0] max_cnt_lp = cnt_w_lp'(max_outstanding_p);
    localparam logic [age_w_lp-1:0] timeout_lp = age_w_lp'(timeout_p);

    logic [paddr_width_p-1:0] r_addr_mem [max_outstanding_p];
    logic [3:0]               r_op_mem   [max_outstanding_p];
    logic [ptr_w_lp-1:0]      r_head;
    logic [ptr_w_lp-1:0]      r_tail;
    logic [cnt_w_lp-1:0]      r_count;
    logic [age_w_lp-1:0]      r_age;
    logic                     r_timeout_seen;
    logic [31:0]              r_cmd_count;
    logic [31:0]              r_resp_count;
    logic [31:0]              r_cycle;
    logic                     r_error;
    logic [2:0]               r_error_code;

    logic                     w_cmd_fire;
    logic                     w_resp_fire;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_age_clear;
    logic                     w_timeout;
    logic [2:0]               w_err_code;
    logic [paddr_width_p-1:0] w_err_addr;

    assign w_cmd_fire  = mem_cmd_v_i & mem_cmd_ready_and_i;
    assign w_resp_fire = mem_resp_v_i & mem_resp_ready_and_i;
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == max_cnt_lp);
    // A response on a non-empty tracker always pops, which frees the slot for
    // a same-cycle command even when full; an empty-tracker response pops nothing.
    assign w_pop       = w_resp_fire & ~w_empty;
    assign w_push      = w_cmd_fire & (~w_full | w_resp_fire);
    assign w_age_clear = w_pop | (w_push & w_empty);
    // Age saturates at timeout_p, so the seen flag is what stops repeats.
    assign w_timeout   = (r_age == timeout_lp) & ~r_timeout_seen;

    always_comb begin
        w_err_code = 3'd0;
        w_err_addr = '0;
        if (w_resp_fire && w_empty) begin
            w_err_code = 3'd1;
            w_err_addr = mem_resp_addr_i;
        end else if (w_resp_fire && (mem_resp_addr_i != r_addr_mem[r_head])) begin
            w_err_code = 3'd2;
            w_err_addr = mem_resp_addr_i;
        end else if (w_resp_fire && (mem_resp_opcode_i != r_op_mem[r_head])) begin
            w_err_code = 3'd3;
            w_err_addr = mem_resp_addr_i;
        end else if (w_cmd_fire && w_full && !w_resp_fire) begin
            w_err_code = 3'd4;
            w_err_addr = mem_cmd_addr_i;
        end else if (w_timeout) begin
            w_err_code = 3'd5;
            w_err_addr = r_addr_mem[r_head];
        end
    end

    // Entry storage carries no reset; validity is defined by the pointers/count.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && w_push) begin
            r_addr_mem[r_tail] <= mem_cmd_addr_i;
            r_op_mem[r_tail]   <= mem_cmd_opcode_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_age          <= '0;
            r_timeout_seen <= 1'b0;
            r_cmd_count    <= '0;
            r_resp_count   <= '0;
            r_cycle        <= '0;
            r_error        <= 1'b0;
            r_error_code   <= 3'd0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_cmd_fire)  r_cmd_count  <= r_cmd_count + 32'd1;
            if (w_resp_fire) r_resp_count <= r_resp_count + 32'd1;
            if (w_pop)  r_head <= r_head + ptr_w_lp'(1);
            if (w_push) r_tail <= r_tail + ptr_w_lp'(1);
            r_count <= r_count + cnt_w_lp'(w_push) - cnt_w_lp'(w_pop);

            if (w_timeout) r_timeout_seen <= 1'b1;
            if (w_age_clear) begin
                r_age          <= '0;
                r_timeout_seen <= 1'b0;
            end else if (!w_empty && (r_age != timeout_lp)) begin
                r_age <= r_age + age_w_lp'(1);
            end

            if (!r_error && (w_err_code != 3'd0)) begin
                r_error      <= 1'b1;
                r_error_code <= w_err_code;
                if (fatal_on_error_p != 0) begin
                    $fatal(1, "mem_if_monitor error code %0d addr 0x%0h cycle %0d",
                           w_err_code, w_err_addr, r_cycle);
                end
            end
        end
    end

    assign outstanding_o = r_count;
    assign cmd_count_o   = r_cmd_count;
    assign resp_count_o  = r_resp_count;
    assign error_o       = r_error;
    assign error_code_o  = r_error_code;
endmodule

// File: tb/tb_bp_nonsynth_mem_if_monitor.sv
// tb/tb_bp_nonsynth_mem_if_monitor.sv - self-checking bench for bp_nonsynth_mem_if_monitor
module tb_bp_nonsynth_mem_if_monitor;
    localparam int AW  = 40;
    localparam int MAX = 4;
    localparam int TO  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] cmd_addr, resp_addr;
    logic [3:0]    cmd_op, resp_op;
    logic          cmd_v, cmd_rdy, resp_v, resp_rdy;
    logic [2:0]    outstanding;
    logic [31:0]   cmd_count, resp_count;
    logic          error;
    logic [2:0]    error_code;

    always #5 clk = ~clk;

    bp_nonsynth_mem_if_monitor #(
        .paddr_width_p(AW), .max_outstanding_p(MAX), .timeout_p(TO), .fatal_on_error_p(0)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .mem_cmd_addr_i(cmd_addr), .mem_cmd_opcode_i(cmd_op),
        .mem_cmd_v_i(cmd_v), .mem_cmd_ready_and_i(cmd_rdy),
        .mem_resp_addr_i(resp_addr), .mem_resp_opcode_i(resp_op),
        .mem_resp_v_i(resp_v), .mem_resp_ready_and_i(resp_rdy),
        .outstanding_o(outstanding), .cmd_count_o(cmd_count), .resp_count_o(resp_count),
        .error_o(error), .error_code_o(error_code)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    op;
    } ent_t;

    ent_t        m_q[$];
    int unsigned m_cmdc, m_respc;
    int          m_age;
    bit          m_to_seen;
    bit          m_err;
    int          m_code;
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: applies the link rules for one clock edge using the
    // inputs the bench is driving.
    task automatic model_edge();
        int  cnt;
        int  code;
        bit  popped, pushed;
        ent_t e;
        if (!rst_n) begin
            m_q.delete();
            m_cmdc = 0; m_respc = 0; m_age = 0; m_to_seen = 0; m_err = 0; m_code = 0;
            return;
        end
        cnt = m_q.size();
        code = 0; popped = 0; pushed = 0;
        if (resp_v && resp_rdy) begin
            m_respc++;
            if (cnt == 0) code = 1;
            else begin
                if (resp_addr != m_q[0].addr) code = 2;
                else if (resp_op != m_q[0].op) code = 3;
                void'(m_q.pop_front());
                popped = 1;
            end
        end
        if (cmd_v && cmd_rdy) begin
            m_cmdc++;
            if (cnt == MAX && !(resp_v && resp_rdy)) begin
                if (code == 0) code = 4;
            end else begin
                e.addr = cmd_addr; e.op = cmd_op;
                m_q.push_back(e);
                pushed = 1;
            end
        end
        if (m_age == TO && !m_to_seen) begin
            if (code == 0) code = 5;
            m_to_seen = 1;
        end
        if (popped || (pushed && cnt == 0)) begin
            m_age = 0; m_to_seen = 0;
        end else if (cnt > 0 && m_age < TO) begin
            m_age++;
        end
        if (!m_err && code != 0) begin
            m_err = 1; m_code = code;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("outstanding", 32'(outstanding), 32'(m_q.size()));
        chk("cmd_count", cmd_count, m_cmdc);
        chk("resp_count", resp_count, m_respc);
        chk("error", 32'(error), 32'(m_err));
        chk("error_code", 32'(error_code), 32'(m_code));
    endtask

    task automatic idle();
        cmd_v = 0; resp_v = 0; cmd_rdy = 1; resp_rdy = 1;
    endtask

    task automatic cyc(bit cv, logic [AW-1:0] ca, logic [3:0] co,
                       bit rv, logic [AW-1:0] ra, logic [3:0] ro);
        cmd_v = cv; cmd_addr = ca; cmd_op = co; cmd_rdy = 1;
        resp_v = rv; resp_addr = ra; resp_op = ro; resp_rdy = 1;
        step();
        idle();
    endtask

    task automatic do_reset();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    initial begin
        int exp_out[6];
        rst_n = 0; cmd_addr = '0; resp_addr = '0; cmd_op = '0; resp_op = '0;
        idle();
        step();
        step();
        rst_n = 1;
        chk("reset_error", 32'(error), 32'd0);
        chk("reset_code", 32'(error_code), 32'd0);

        // In-order matching traffic
        exp_out = '{1, 2, 3, 2, 1, 0};
        for (int i = 0; i < 3; i++) begin
            cyc(1, 40'h8000_0000 + 40'(i * 'h40), 4'd1, 0, '0, '0);
            chk("seq_outstanding", 32'(outstanding), 32'(exp_out[i]));
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, '0, '0, 1, 40'h8000_0000 + 40'(i * 'h40), 4'd1);
            chk("seq_outstanding", 32'(outstanding), 32'(exp_out[3+i]));
        end
        chk("seq_cmd_count", cmd_count, 32'd3);
        chk("seq_resp_count", resp_count, 32'd3);
        chk("seq_error", 32'(error), 32'd0);

        // Valid without ready is ignored
        cmd_v = 1; cmd_rdy = 0; resp_v = 1; resp_rdy = 0;
        step();
        idle();
        chk("noready_cmd_count", cmd_count, 32'd3);

        // Orphan response, later mismatch does not overwrite
        do_reset();
        cyc(0, '0, '0, 1, 40'h1234, 4'd2);
        chk("orphan_code", 32'(error_code), 32'd1);
        cyc(1, 40'h1000, 4'd1, 0, '0, '0);
        cyc(0, '0, '0, 1, 40'h5000, 4'd1);
        chk("orphan_sticky", 32'(error_code), 32'd1);

        // Address mismatch
        do_reset();
        cyc(1, 40'h1000, 4'd1, 0, '0, '0);
        cyc(1, 40'h2000, 4'd1, 0, '0, '0);
        cyc(0, '0, '0, 1, 40'h2000, 4'd1);
        chk("addr_mis_code", 32'(error_code), 32'd2);
        chk("addr_mis_out", 32'(outstanding), 32'd1);

        // Opcode mismatch
        do_reset();
        cyc(1, 40'h3000, 4'd2, 0, '0, '0);
        cyc(0, '0, '0, 1, 40'h3000, 4'd5);
        chk("op_mis_code", 32'(error_code), 32'd3);

        // Overflow
        do_reset();
        for (int i = 0; i < MAX; i++) cyc(1, 40'(i * 'h100), 4'd1, 0, '0, '0);
        cyc(1, 40'hF00, 4'd1, 0, '0, '0);
        chk("ovf_code", 32'(error_code), 32'd4);
        chk("ovf_out", 32'(outstanding), 32'd4);
        chk("ovf_cmd_count", cmd_count, 32'd5);

        // Full with simultaneous command and matching response
        do_reset();
        for (int i = 0; i < MAX; i++) cyc(1, 40'(i * 'h100), 4'd1, 0, '0, '0);
        cyc(1, 40'hF00, 4'd1, 1, 40'h0, 4'd1);
        chk("full_swap_error", 32'(error), 32'd0);
        chk("full_swap_out", 32'(outstanding), 32'd4);

        // Empty with simultaneous command and response
        do_reset();
        cyc(1, 40'h700, 4'd1, 1, 40'h700, 4'd1);
        chk("zero_lat_code", 32'(error_code), 32'd1);
        chk("zero_lat_out", 32'(outstanding), 32'd1);

        // Timeout
        do_reset();
        cyc(1, 40'h4000, 4'd1, 0, '0, '0);
        for (int i = 0; i < TO; i++) step();
        chk("timeout_early", 32'(error), 32'd0);
        step();
        chk("timeout_error", 32'(error), 32'd1);
        chk("timeout_code", 32'(error_code), 32'd5);

        // Response just before timeout
        do_reset();
        cyc(1, 40'h4000, 4'd1, 0, '0, '0);
        for (int i = 0; i < TO - 2; i++) step();
        cyc(0, '0, '0, 1, 40'h4000, 4'd1);
        for (int i = 0; i < 20; i++) step();
        chk("no_timeout", 32'(error), 32'd0);

        // Reset mid-operation
        do_reset();
        cyc(1, 40'h10, 4'd1, 0, '0, '0);
        cyc(1, 40'h20, 4'd1, 0, '0, '0);
        do_reset();
        chk("midreset_out", 32'(outstanding), 32'd0);
        chk("midreset_cmd", cmd_count, 32'd0);
        cyc(0, '0, '0, 1, 40'h10, 4'd1);
        chk("midreset_orphan", 32'(error_code), 32'd1);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst_n    = ($urandom_range(0, 79) != 0);
            cmd_v    = $urandom_range(0, 1);
            cmd_rdy  = ($urandom_range(0, 3) != 0);
            cmd_addr = 40'($urandom_range(0, 7) * 'h40);
            cmd_op   = 4'($urandom_range(0, 1));
            resp_v   = $urandom_range(0, 1);
            resp_rdy = ($urandom_range(0, 3) != 0);
            if (m_q.size() > 0 && $urandom_range(0, 15) != 0) begin
                resp_addr = m_q[0].addr;
                resp_op   = m_q[0].op;
            end else begin
                resp_addr = 40'($urandom_range(0, 7) * 'h40);
                resp_op   = 4'($urandom_range(0, 1));
            end
            step();
        end
        rst_n = 1;
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/bp_nonsynth_mem_if_monitor.md
# bp_nonsynth_mem_if_monitor

Non-synthesizable runtime protocol monitor for the BedRock CCE-to-memory link. It is instantiated beside the static parameter/width checks in the testbench. It taps the mem command and mem response ready-valid channels without driving them. It tracks outstanding commands in order, checks every response against the oldest outstanding command, and flags orphan responses, mismatches, overflow and timeouts through sticky status outputs.

## Interface
Parameters:
- paddr_width_p, 40, address field width of command and response headers
- max_outstanding_p, 8, depth of the outstanding-command tracker (power of 2, >= 2)
- timeout_p, 1024, cycles the oldest command may remain outstanding before a timeout error
- fatal_on_error_p, 0, 1: call $fatal on the first error; 0: record the error only

Ports:
- clk_i  input  1  clock; all logic on the rising edge
- reset_n_i  input  1  reset, synchronous and active-low
- mem_cmd_addr_i  input  paddr_width_p  command header address
- mem_cmd_opcode_i  input  4  command header msg_type
- mem_cmd_v_i  input  1  command valid
- mem_cmd_ready_and_i  input  1  command ready (ready-and)
- mem_resp_addr_i  input  paddr_width_p  response header address
- mem_resp_opcode_i  input  4  response header msg_type
- mem_resp_v_i  input  1  response valid
- mem_resp_ready_and_i  input  1  response ready (ready-and)
- outstanding_o  output  $clog2(max_outstanding_p+1)  commands currently tracked
- cmd_count_o  output  32  accepted commands, wraps modulo 2^32
- resp_count_o  output  32  accepted responses, wraps modulo 2^32
- error_o  output  1  sticky: at least one error detected
- error_code_o  output  3  code of the first error: 0 none, 1 orphan response, 2 address mismatch, 3 opcode mismatch, 4 overflow, 5 timeout

## Operation
- Command fire (cmd_fire) = mem_cmd_v_i & mem_cmd_ready_and_i. Response fire (resp_fire) = mem_resp_v_i & mem_resp_ready_and_i. Valid without ready is ignored.
- Tracker: circular FIFO of {addr, opcode} with depth max_outstanding_p, plus head/tail pointers and a count. Responses are in order with respect to commands.
- On cmd_fire, push {addr, opcode} and increment cmd_count_o.
- On resp_fire, increment resp_count_o and apply the first matching rule:
  - tracker empty: error 1, nothing popped;
  - resp addr != head addr: error 2, pop;
  - resp opcode != head opcode: error 3, pop;
  - otherwise: pop, no error.
- Overflow: cmd_fire when count == max_outstanding_p and there is no resp_fire in the same cycle. Raise error 4 and drop the command (no push). cmd_count_o still increments.
- Full tracker with simultaneous cmd_fire and resp_fire: pop then push. No overflow; count unchanged.
- Empty tracker with simultaneous cmd_fire and resp_fire: error 1 (zero-latency responses are illegal), then push the command.
- Age counter, width $clog2(timeout_p+1), saturating:
  - cleared on reset, on any pop, and on a push into an empty tracker;
  - otherwise increments each cycle while count > 0.
- Timeout: age reaches timeout_p. Raise error 5 once, with no repeat until the age is cleared.
- Error priority within one cycle: 1/2/3 > 4 > 5.
- error_code_o latches only the first error after reset; later errors change nothing. Tracking and counting continue after an error.
- With fatal_on_error_p = 1, $fatal fires in the cycle the first error is latched, with a message naming the code, address and cycle count.

## Timing
- All outputs are registered and update on the edge following the fire/age condition (1-cycle latency).
- A reset_n_i low sampled at an edge clears count, pointers, age, counters, error_o and error_code_o on that edge. Everything reads 0 the following cycle.
- Reset mid-operation discards all outstanding entries. Responses after reset to pre-reset commands report error 1.
- Fires are ignored in any cycle where reset_n_i is low.
- Pointers wrap modulo max_outstanding_p; count never exceeds max_outstanding_p.

## Test plan
- Reset, then 3 commands (addr 0x80000000/0x80000040/0x80000080, opcode 1) followed by 3 in-order matching responses -> outstanding_o 1,2,3,2,1,0; cmd_count_o = resp_count_o = 3; error_o 0.
- Response fire with empty tracker -> error_o 1, error_code_o 1 on the next edge. A later address mismatch leaves error_code_o at 1.
- Commands A=0x1000 then B=0x2000; response addr 0x2000 -> error_code_o 2, outstanding_o 1.
- max_outstanding_p = 4: 4 commands, then a 5th command with no response -> error_code_o 4, outstanding_o stays 4. Separate run: 5th command together with a matching response -> no error, outstanding_o 4.
- timeout_p = 16: one command and no response -> error_o rises exactly 16 cycles after the fire edge plus 1 registered cycle. Same setup with a response at cycle 15 -> no error.
- 2 commands outstanding, assert reset_n_i low for 1 cycle -> all outputs 0. A subsequent response -> error_code_o 1.
